// File: rtl/stdp_pkg.sv
// Shared STDP constants: probability width, LFSR taps and seed, and the
// probability edge-case encodings also used by the edge selector.
package stdp_pkg;

  localparam int PROB_W = 7;

  typedef logic [PROB_W-1:0] prob_t;

  // Taps for x^7 + x^6 + 1: feedback is q[6] ^ q[5].
  localparam prob_t LFSR_POLY     = 7'h60;
  localparam prob_t LFSR_SEED_DEF = 7'h5A;

  localparam prob_t PROB_NEVER  = 7'd0;
  localparam prob_t PROB_ALWAYS = 7'd127;

  function automatic prob_t lfsr_next(input prob_t q);
    return {q[PROB_W-2:0], ^(q & LFSR_POLY)};
  endfunction

endpackage

// File: rtl/stdp_lfsr7.sv
// Free-running 7-bit Fibonacci LFSR (period 127), advances every cycle.
// Latency: q is the registered state; no backpressure, never stalls.
module stdp_lfsr7
  import stdp_pkg::*;
#(
  parameter prob_t SEED = LFSR_SEED_DEF
) (
  input  logic  clk,
  input  logic  rst_n,
  output prob_t q
);

  // An all-zero state would lock up the register, so a zero seed becomes 1.
  localparam prob_t SEED_SAFE = (SEED == PROB_NEVER) ? 7'h01 : SEED;

  prob_t lfsr_q;
  prob_t lfsr_d;

  always_comb begin
    lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED_SAFE;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/stdp_weight_update.sv
// Stochastic STDP update: accept -> upd_valid in 2 cycles, 1 req/cycle, in_ready = learn_en only.
// Optional STDP_STAT_CNT_EN adds saturating potentiation/depression counters with stat_clr.
module stdp_weight_update
  import stdp_pkg::*;
#(
  parameter int    NUM_SYN   = 64,
  parameter int    ADDR_W    = $clog2(NUM_SYN),
  parameter int    WEIGHT_W  = 3,
  parameter int    INIT_W    = 0,
  parameter prob_t LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                learn_en,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   in_addr,
  input  prob_t               in_prob,
  input  logic                in_inc,
  input  logic                host_wr_en,
  input  logic [ADDR_W-1:0]   host_addr,
  input  logic [WEIGHT_W-1:0] host_wdata,
  output logic [WEIGHT_W-1:0] host_rdata,
`ifdef STDP_STAT_CNT_EN
  input  logic                stat_clr,
  output logic [15:0]         pot_cnt,
  output logic [15:0]         dep_cnt,
`endif
  output logic                upd_valid,
  output logic [ADDR_W-1:0]   upd_addr,
  output logic [WEIGHT_W-1:0] upd_weight,
  output logic                upd_changed
);

  typedef logic [WEIGHT_W-1:0] weight_t;

  localparam weight_t WMAX  = '1;
  localparam weight_t W_RST = weight_t'(INIT_W);

  prob_t lfsr;

  stdp_lfsr7 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr)
  );

  logic              accept;
  logic              a_vld_q, a_vld_d;
  logic [ADDR_W-1:0] a_addr_q, a_addr_d;
  logic              a_inc_q, a_inc_d;
  logic              a_fire_q, a_fire_d;

  weight_t weight_q [NUM_SYN];
  weight_t weight_d [NUM_SYN];

  weight_t b_cur;
  weight_t b_new;
  logic    b_host_hit;

  logic              upd_valid_q, upd_valid_d;
  logic [ADDR_W-1:0] upd_addr_q, upd_addr_d;
  weight_t           upd_weight_q, upd_weight_d;
  logic              upd_changed_q, upd_changed_d;

  assign in_ready = learn_en;
  assign accept   = in_valid & learn_en;

  // Stage A: the hit decision is taken against this cycle's LFSR sample.
  always_comb begin
    a_vld_d  = accept;
    a_addr_d = a_addr_q;
    a_inc_d  = a_inc_q;
    a_fire_d = a_fire_q;
    if (accept) begin
      a_addr_d = in_addr;
      a_inc_d  = in_inc;
      a_fire_d = (in_prob == PROB_ALWAYS) ||
                 ((in_prob != PROB_NEVER) && (lfsr <= in_prob));
    end
  end

  // Stage B: read-modify-write; a back-to-back request sees the value written at this edge.
  always_comb begin
    b_cur = weight_q[a_addr_q];
    b_new = b_cur;
    if (a_fire_q && a_inc_q && (b_cur != WMAX)) begin
      b_new = b_cur + weight_t'(1);
    end else if (a_fire_q && !a_inc_q && (b_cur != '0)) begin
      b_new = b_cur - weight_t'(1);
    end
    b_host_hit = host_wr_en && (host_addr == a_addr_q);
  end

  // Host write is applied last so it overrides a learning write to the same entry.
  always_comb begin
    weight_d = weight_q;
    if (a_vld_q) begin
      weight_d[a_addr_q] = b_new;
    end
    if (host_wr_en) begin
      weight_d[host_addr] = host_wdata;
    end
  end

  always_comb begin
    upd_valid_d   = a_vld_q;
    upd_addr_d    = upd_addr_q;
    upd_weight_d  = upd_weight_q;
    upd_changed_d = upd_changed_q;
    if (a_vld_q) begin
      upd_addr_d = a_addr_q;
      if (b_host_hit) begin
        upd_weight_d  = host_wdata;
        upd_changed_d = 1'b0;
      end else begin
        upd_weight_d  = b_new;
        upd_changed_d = (b_new != b_cur);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_vld_q       <= 1'b0;
      a_addr_q      <= '0;
      a_inc_q       <= 1'b0;
      a_fire_q      <= 1'b0;
      upd_valid_q   <= 1'b0;
      upd_addr_q    <= '0;
      upd_weight_q  <= '0;
      upd_changed_q <= 1'b0;
      for (int i = 0; i < NUM_SYN; i++) begin
        weight_q[i] <= W_RST;
      end
    end else begin
      a_vld_q       <= a_vld_d;
      a_addr_q      <= a_addr_d;
      a_inc_q       <= a_inc_d;
      a_fire_q      <= a_fire_d;
      upd_valid_q   <= upd_valid_d;
      upd_addr_q    <= upd_addr_d;
      upd_weight_q  <= upd_weight_d;
      upd_changed_q <= upd_changed_d;
      weight_q      <= weight_d;
    end
  end

  assign host_rdata  = weight_q[host_addr];
  assign upd_valid   = upd_valid_q;
  assign upd_addr    = upd_addr_q;
  assign upd_weight  = upd_weight_q;
  assign upd_changed = upd_changed_q;

`ifdef STDP_STAT_CNT_EN
  logic [15:0] pot_cnt_q, pot_cnt_d;
  logic [15:0] dep_cnt_q, dep_cnt_d;

  // Only stage-B results that really moved the weight are counted.
  always_comb begin
    pot_cnt_d = pot_cnt_q;
    dep_cnt_d = dep_cnt_q;
    if (stat_clr) begin
      pot_cnt_d = '0;
      dep_cnt_d = '0;
    end else if (a_vld_q && upd_changed_d) begin
      if (a_inc_q && (pot_cnt_q != 16'hFFFF)) begin
        pot_cnt_d = pot_cnt_q + 16'd1;
      end else if (!a_inc_q && (dep_cnt_q != 16'hFFFF)) begin
        dep_cnt_d = dep_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pot_cnt_q <= '0;
      dep_cnt_q <= '0;
    end else begin
      pot_cnt_q <= pot_cnt_d;
      dep_cnt_q <= dep_cnt_d;
    end
  end

  assign pot_cnt = pot_cnt_q;
  assign dep_cnt = dep_cnt_q;
`endif

endmodule

// File: tb/tb_stdp_weight_update.sv
// Bench for stdp_weight_update: directed scenarios plus randomized traffic,
// checked every cycle against a cycle-indexed behavioural model.
`timescale 1ns/1ps
module tb_stdp_weight_update;

  localparam int NUM_SYN  = 64;
  localparam int ADDR_W   = 6;
  localparam int WEIGHT_W = 3;
  localparam int INIT_W   = 2;
  localparam int WMAX     = (1 << WEIGHT_W) - 1;
  localparam logic [6:0] SEED = 7'h5A;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic learn_en = 1'b0;
  logic in_valid = 1'b0;
  logic in_inc = 1'b0;
  logic host_wr_en = 1'b0;
  logic [ADDR_W-1:0] in_addr = '0;
  logic [ADDR_W-1:0] host_addr = '0;
  logic [6:0] in_prob = '0;
  logic [WEIGHT_W-1:0] host_wdata = '0;
  logic in_ready;
  logic [WEIGHT_W-1:0] host_rdata;
  logic upd_valid;
  logic [ADDR_W-1:0] upd_addr;
  logic [WEIGHT_W-1:0] upd_weight;
  logic upd_changed;
`ifdef STDP_STAT_CNT_EN
  logic stat_clr = 1'b0;
  logic [15:0] pot_cnt;
  logic [15:0] dep_cnt;
`endif

  always #5 clk = ~clk;

  stdp_weight_update #(
    .NUM_SYN(NUM_SYN), .ADDR_W(ADDR_W), .WEIGHT_W(WEIGHT_W),
    .INIT_W(INIT_W), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .learn_en(learn_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_prob(in_prob), .in_inc(in_inc),
    .host_wr_en(host_wr_en), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata),
`ifdef STDP_STAT_CNT_EN
    .stat_clr(stat_clr), .pot_cnt(pot_cnt), .dep_cnt(dep_cnt),
`endif
    .upd_valid(upd_valid), .upd_addr(upd_addr),
    .upd_weight(upd_weight), .upd_changed(upd_changed)
  );

  int nvec = 0;
  int nerr = 0;
  int n_upd = 0;
  int n_chg = 0;

  task automatic check(input string nm, input int act, input int want);
    nvec++;
    if (act != want) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, want, $time);
    end
  endtask

  // Behavioural model: LFSR sample is a table lookup by cycle count since reset;
  // a request accepted at one edge lands in the array at the following edge.
  logic [6:0] seq [127];
  int m_w [NUM_SYN];
  int m_cyc;
  bit pa_vld, pa_inc, pa_fire;
  int pa_addr;
  bit e_vld, e_chg;
  int e_addr, e_wt;
  int m_old, m_new;

  initial begin
    logic [6:0] s;
    s = (SEED == 7'h00) ? 7'h01 : SEED;
    for (int i = 0; i < 127; i++) begin
      seq[i] = s;
      s = {s[5:0], s[6] ^ s[5]};
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SYN; i++) m_w[i] = INIT_W;
      m_cyc = 0; pa_vld = 0; pa_inc = 0; pa_fire = 0; pa_addr = 0;
      e_vld = 0; e_chg = 0; e_addr = 0; e_wt = 0;
    end else begin
      e_vld = pa_vld;
      if (pa_vld) begin
        m_old = m_w[pa_addr];
        m_new = m_old;
        if (pa_fire && pa_inc && m_old < WMAX) m_new = m_old + 1;
        if (pa_fire && !pa_inc && m_old > 0) m_new = m_old - 1;
        m_w[pa_addr] = m_new;
        e_addr = pa_addr;
        if (host_wr_en && int'(host_addr) == pa_addr) begin
          e_wt = int'(host_wdata); e_chg = 0;
        end else begin
          e_wt = m_new; e_chg = (m_new != m_old);
        end
      end
      if (host_wr_en) m_w[host_addr] = int'(host_wdata);
      pa_vld = learn_en && in_valid;
      if (pa_vld) begin
        pa_addr = int'(in_addr);
        pa_inc  = in_inc;
        pa_fire = (in_prob != 7'd0) && (seq[m_cyc % 127] <= in_prob);
      end
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_upd_valid", int'(upd_valid), 0);
    end else begin
      check("in_ready", int'(in_ready), int'(learn_en));
      check("upd_valid", int'(upd_valid), int'(e_vld));
      if (e_vld) begin
        check("upd_addr", int'(upd_addr), e_addr);
        check("upd_weight", int'(upd_weight), e_wt);
        check("upd_changed", int'(upd_changed), int'(e_chg));
      end
      check("host_rdata", int'(host_rdata), m_w[host_addr]);
      if (upd_valid) n_upd++;
      if (upd_valid && upd_changed) n_chg++;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_steps(input int n);
    in_valid = 1'b0;
    host_wr_en = 1'b0;
    repeat (n) step();
  endtask

  task automatic host_wr(input int a, input int d);
    host_wr_en = 1'b1; host_addr = ADDR_W'(a); host_wdata = WEIGHT_W'(d);
    step();
    host_wr_en = 1'b0;
  endtask

  task automatic rd_lit(input string nm, input int a, input int want);
    host_addr = ADDR_W'(a);
    @(negedge clk);
    check(nm, int'(host_rdata), want);
    step();
  endtask

  // Reset pulse inside one cycle; a request is presented as reset releases so
  // it meets the first post-reset LFSR value.
  task automatic reset_then_req(input int a, input int p);
    in_valid = 1'b0; host_wr_en = 1'b0;
    rst_n = 1'b0;
    #4;
    rst_n = 1'b1;
    in_valid = 1'b1; in_addr = ADDR_W'(a); in_prob = 7'(p); in_inc = 1'b1;
    step();
    idle_steps(2);
  endtask

  int snap;

  initial begin
    learn_en = 1'b1;
    #22 rst_n = 1'b1;

    for (int a = 0; a < NUM_SYN; a++) rd_lit("lit_reset_weight", a, INIT_W);

    // Four potentiations at addr 5 from INIT_W: 3,4,5,6.
    snap = n_chg;
    in_valid = 1'b1; in_addr = 6'd5; in_prob = 7'd127; in_inc = 1'b1;
    repeat (4) step();
    idle_steps(3);
    check("lit_pot4_changes", n_chg - snap, 4);
    rd_lit("lit_pot4_weight", 5, 6);

    // Eight potentiations at addr 6: saturates at WMAX after five.
    snap = n_chg;
    in_valid = 1'b1; in_addr = 6'd6; in_prob = 7'd127; in_inc = 1'b1;
    repeat (8) step();
    idle_steps(3);
    check("lit_sat_hi_changes", n_chg - snap, 5);
    rd_lit("lit_sat_hi_weight", 6, 7);

    // Depression from 1 at addr 7: one change, then stuck at 0.
    host_wr(7, 1);
    snap = n_chg;
    in_valid = 1'b1; in_addr = 6'd7; in_prob = 7'd127; in_inc = 1'b0;
    repeat (3) step();
    idle_steps(3);
    check("lit_sat_lo_changes", n_chg - snap, 1);
    rd_lit("lit_sat_lo_weight", 7, 0);

    // prob=0 never fires.
    snap = n_chg;
    for (int i = 0; i < 127; i++) begin
      in_valid = 1'b1; in_addr = ADDR_W'($urandom_range(0, NUM_SYN-1));
      in_prob = 7'd0; in_inc = 1'($urandom_range(0, 1));
      step();
    end
    idle_steps(3);
    check("lit_prob0_changes", n_chg - snap, 0);

    // prob=64 over one full LFSR period fires exactly 64 times (no saturation possible).
    for (int a = 0; a < NUM_SYN; a++) host_wr(a, 0);
    snap = n_chg;
    for (int i = 0; i < 127; i++) begin
      in_valid = 1'b1; in_addr = ADDR_W'(i % NUM_SYN); in_prob = 7'd64; in_inc = 1'b1;
      step();
    end
    idle_steps(3);
    check("lit_prob64_fires", n_chg - snap, 64);

    // Host write collides with stage B of an update to addr 3.
    host_wr(3, 1);
    in_valid = 1'b1; in_addr = 6'd3; in_prob = 7'd127; in_inc = 1'b1;
    step();
    in_valid = 1'b0;
    host_wr_en = 1'b1; host_addr = 6'd3; host_wdata = 3'd6;
    step();
    host_wr_en = 1'b0;
    @(negedge clk);
    check("lit_coll_upd_valid", int'(upd_valid), 1);
    check("lit_coll_upd_weight", int'(upd_weight), 6);
    check("lit_coll_upd_changed", int'(upd_changed), 0);
    check("lit_coll_weight", int'(host_rdata), 6);
    step();

    // learn_en low: nothing accepted.
    idle_steps(2);
    snap = n_upd;
    learn_en = 1'b0;
    in_valid = 1'b1; in_addr = 6'd9; in_prob = 7'd127; in_inc = 1'b1;
    @(negedge clk);
    check("lit_ready_low", int'(in_ready), 0);
    repeat (10) step();
    in_valid = 1'b0;
    learn_en = 1'b1;
    idle_steps(3);
    check("lit_learn_off_upd", n_upd - snap, 0);

    // Reset one cycle after an accept drops it; seed decides the first post-reset draw.
    host_wr(5, 4);
    snap = n_upd;
    in_valid = 1'b1; in_addr = 6'd5; in_prob = 7'd127; in_inc = 1'b1;
    step();
    reset_then_req(10, 32'h5A);
    check("lit_reset_drop_upd", n_upd - snap, 1);
    rd_lit("lit_reset_weight5", 5, INIT_W);
    rd_lit("lit_seed_hit", 10, INIT_W + 1);
    reset_then_req(11, 32'h59);
    rd_lit("lit_seed_miss", 11, INIT_W);
    rd_lit("lit_seed_reset10", 10, INIT_W);

    // Randomized traffic on a small address window to exercise hazards and collisions.
    for (int i = 0; i < 2000; i++) begin
      learn_en   = ($urandom_range(0, 9) != 0);
      in_valid   = 1'($urandom_range(0, 3) != 0);
      in_addr    = ADDR_W'($urandom_range(0, 7));
      in_prob    = 7'($urandom_range(0, 127));
      in_inc     = 1'($urandom_range(0, 1));
      host_wr_en = ($urandom_range(0, 5) == 0);
      host_addr  = ADDR_W'($urandom_range(0, 7));
      host_wdata = WEIGHT_W'($urandom_range(0, WMAX));
      step();
    end
    learn_en = 1'b1;
    idle_steps(4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/stdp_weight_update.md
Name: stdp_weight_update

Overview:
- Stochastic STDP weight-update stage, directly downstream of the edge-selection logic.
- Consumes each {prob, inc} decision together with a synapse index.
- Draws a 7-bit LFSR sample and compares it against prob; on a hit, increments or decrements that synapse's saturating weight in a local register-file.
- Exposes a host read/write port for initialisation and readout, plus a per-update result strobe.

Parameters:
- NUM_SYN, 64, number of synapses (weight entries).
- ADDR_W, $clog2(NUM_SYN), synapse index width.
- WEIGHT_W, 3, weight width; WMAX = 2**WEIGHT_W-1.
- INIT_W, 0, weight value loaded into every entry on reset.
- LFSR_SEED, 7'h5A, LFSR reset value; a value of 0 is replaced by 7'h01.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- learn_en  in  1  learning enable; gates acceptance
- in_valid  in  1  update request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_addr  in  ADDR_W  synapse index
- in_prob  in  7  update probability, 0..127
- in_inc  in  1  1 = potentiate, 0 = depress
- host_wr_en  in  1  host weight write
- host_addr  in  ADDR_W  host read/write index
- host_wdata  in  WEIGHT_W  host write data
- host_rdata  out  WEIGHT_W  combinational read of weight[host_addr]
- upd_valid  out  1  one-cycle result strobe
- upd_addr  out  ADDR_W  index of the completed update
- upd_weight  out  WEIGHT_W  weight after the update
- upd_changed  out  1  weight actually changed

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - All weights = INIT_W.
  - LFSR = LFSR_SEED (7'h01 if LFSR_SEED==0).
  - upd_valid, upd_addr, upd_weight, upd_changed = 0.
  - Stage-A valid = 0.
- LFSR:
  - 7-bit Fibonacci, polynomial x^7+x^6+1, shift left, feedback = q[6]^q[5].
  - Advances every cycle after reset, independent of traffic.
  - Period 127; never 0.
- in_ready = learn_en. There is no other backpressure; the pipeline never stalls.
- Stage A (accept cycle):
  - On handshake, register addr and inc.
  - Register fire = (lfsr_q <= in_prob) && (in_prob != 0), using the LFSR value of the same cycle.
  - prob=0: never fires. prob=127: always fires.
- Stage B (next cycle), read-modify-write of weight[addr]:
  - fire & inc & w<WMAX: w+1.
  - fire & !inc & w>0: w-1.
  - Otherwise (including saturation at WMAX or 0): unchanged.
  - upd_valid=1 on the clock edge ending stage B.
  - upd_weight = post-update value; upd_changed = value differs.
- Latency: accept at cycle N -> array updated and upd_valid high in cycle N+2. Throughput is 1 request per cycle.
- Back-to-back requests to the same addr: stage B of the first writes at the same edge the second is captured in stage A. The second reads the updated weight; no forwarding is needed because the read happens in stage B.
- Host write:
  - Applied at the clock edge; has priority over a stage-B write to the same addr.
  - In that case the learning update is discarded. upd_valid still pulses with upd_weight=host_wdata and upd_changed=0.
  - Host write to a different addr proceeds concurrently.
- host_rdata reflects the array contents at the start of the cycle (pre-write).
- learn_en deasserted: no new acceptances; an in-flight stage-A request still completes.
- rst_n asserted mid-operation: in-flight request dropped, no upd_valid, and all state returns to reset values.

Optional Feature:
- Macro: STDP_STAT_CNT_EN.
- Defined:
  - Adds outputs pot_cnt[15:0] and dep_cnt[15:0], counting stage-B updates with upd_changed=1 for inc=1 and inc=0 respectively.
  - Counters saturate at 16'hFFFF, reset to 0, and are cleared by an added input stat_clr (synchronous, priority over increment).
- Not defined: those ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package stdp_pkg:
  - PROB_W=7
  - LFSR_POLY taps
  - default LFSR_SEED
  - typedef prob_t (logic [6:0])
  - edge-case encoding constants shared with the edge selector
- One sub-module: stdp_lfsr7, holding the LFSR register, seed-zero guard and advance logic, with output q.

Test Plan:
- Reset with INIT_W=2 -> every host_rdata=2; upd_valid=0; LFSR first value = LFSR_SEED.
- in_prob=127, in_inc=1, addr 5, four consecutive requests from w=2 -> upd_weight 3, 4, 5, 6 on cycles N+2..N+5, all upd_changed=1; weight[5]=6.
- Same as above with 8 requests -> reaches 7, then upd_changed=0, weight stays 7. Mirror with inc=0 from w=1 -> 0, then stuck at 0.
- in_prob=0 for 127 requests -> zero changes. in_prob=64 for exactly 127 requests (one full LFSR period, LFSR advancing one step per request) -> exactly 64 fires.
- Host write addr 3 = 6 in the same cycle as stage B of an inc update to addr 3 from w=1 -> weight[3]=6, upd_weight=6, upd_changed=0.
- learn_en low -> in_ready=0, no upd_valid. rst_n pulsed one cycle after accept -> no upd_valid, weights return to INIT_W.
